// File: rtl/alu_share_ctrl_pkg.sv
// alu_share_ctrl_pkg: alu op codes and sharing-controller states
package alu_share_ctrl_pkg;
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_t;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} alu_share_state_t;
endpackage

// File: rtl/alu.sv
// alu: combinational add/sub/and/or/slt with undefined-op flag
module alu
  import alu_share_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ALUControl,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Z,
  output logic             err
);
  always_comb begin
    ALUResult = '0;
    err = 1'b0;
    case (ALUControl)
      ALU_ADD: ALUResult = a + b;
      ALU_SUB: ALUResult = a - b;
      ALU_AND: ALUResult = a & b;
      ALU_OR:  ALUResult = a | b;
      ALU_SLT: ALUResult = {{(WIDTH-1){1'b0}}, a < b};
      default: err = 1'b1;
    endcase
  end
  assign Z = ~|ALUResult;
endmodule

// File: rtl/alu_share_ctrl_arbiter.sv
// rr_arbiter: first requester at or after ptr (wrapping) wins; one-hot grant plus index
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  always_comb begin
    idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) idx = IW'((int'(ptr) + k) % N);
    grant = (|req) ? (N'(1) << idx) : '0;
  end
endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sharing of one alu between NREQ valid/ready requesters
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*3-1:0]     req_op,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]      rsp_result,
  output logic                  rsp_zero,
  output logic                  rsp_err,
  output logic                  busy
);
  localparam int IW = $clog2(NREQ);
  alu_share_state_t r_state;
  logic [IW-1:0]    r_ptr, r_idx, w_idx;
  logic [NREQ-1:0]  w_grant, r_rsp_valid;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b, r_result, w_result;
  logic             r_zero, r_err, w_zero, w_err;
  rr_arbiter #(.N(NREQ)) u_arb (.req(req_valid), .ptr(r_ptr), .grant(w_grant), .idx(w_idx));
  alu #(.WIDTH(WIDTH)) u_alu (
    .a(r_a), .b(r_b), .ALUControl(r_op), .ALUResult(w_result), .Z(w_zero), .err(w_err)
  );
  assign req_ready  = (r_state == S_IDLE) ? w_grant : '0;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_result;
  assign rsp_zero   = r_zero;
  assign rsp_err    = r_err;
  assign busy       = r_state != S_IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_idx       <= '0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_rsp_valid <= '0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (|req_valid) begin
          r_idx   <= w_idx;
          r_op    <= req_op[3*w_idx +: 3];
          r_a     <= req_a[WIDTH*w_idx +: WIDTH];
          r_b     <= req_b[WIDTH*w_idx +: WIDTH];
          r_ptr   <= (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_result    <= w_result;
          r_zero      <= w_zero;
          r_err       <= w_err;
          r_rsp_valid <= NREQ'(1) << r_idx;
          r_state     <= S_RESP;
        end
        S_RESP: if (rsp_ready[r_idx]) begin
          r_rsp_valid <= '0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed and random checks of the shared-alu controller
module tb_alu_share_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [5:0]  req_op;
  logic [63:0] req_a, req_b;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_err, busy;
  int          errs = 0, checks = 0;
  logic [1:0]  pend;
  logic [2:0]  pop [2];
  logic [31:0] pa [2], pb [2];
  logic [33:0] exp_r;
  bit          inflight;
  int          age, owner, nptr, g;
  int          skip [2];
  always #5 clk = ~clk;
  alu_share_ctrl #(.WIDTH(32), .NREQ(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .rsp_err(rsp_err), .busy(busy)
  );
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  // {err, zero, result} from the op table using plain arithmetic
  function automatic logic [33:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    logic e;
    r = 0;
    e = 1'b0;
    case (op)
      3'd0: r = (64'(a) + 64'(b)) % 64'h1_0000_0000;
      3'd1: r = (64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000;
      3'd2: r = 64'(a & b);
      3'd3: r = 64'(a | b);
      3'd5: r = (a < b) ? 64'd1 : 64'd0;
      default: e = 1'b1;
    endcase
    return {e, r == 0, r[31:0]};
  endfunction
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic setop(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[3*i +: 3] = op;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask
  task automatic txn(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [33:0] e;
    logic [1:0] oh;
    e = ref_alu(op, a, b);
    oh = 2'(1 << i);
    setop(i, op, a, b);
    req_valid = oh;
    #1;
    chk("t_ready_same_cycle", req_ready, oh);
    cyc();
    req_valid = 2'b00;
    rsp_ready = oh;
    #1;
    chk("t_exec_busy", busy, 1);
    chk("t_exec_rspv", rsp_valid, 0);
    cyc();
    rsp_ready = 2'b00;
    chk("t_rspv", rsp_valid, oh);
    chk("t_result", rsp_result, e[31:0]);
    chk("t_zero", rsp_zero, e[32]);
    chk("t_err", rsp_err, e[33]);
    for (int h = 0; h < hold; h++) begin
      rsp_ready = ~oh;
      req_valid = 2'b11;
      cyc();
      chk("t_hold_rspv", rsp_valid, oh);
      chk("t_hold_result", {rsp_err, rsp_zero, rsp_result}, e);
      chk("t_hold_ready", req_ready, 0);
    end
    rsp_ready = oh;
    req_valid = 2'b00;
    cyc();
    rsp_ready = 2'b00;
    chk("t_done_rspv", rsp_valid, 0);
    chk("t_done_busy", busy, 0);
  endtask
  initial begin
    reset = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    cyc();
    cyc();
    chk("rst_ready", req_ready, 0);
    chk("rst_rspv", rsp_valid, 0);
    chk("rst_outs", {rsp_err, rsp_zero, rsp_result}, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    cyc();
    txn(0, 3'b000, 32'd5, 32'd7, 0);
    txn(1, 3'b001, 32'd3, 32'd3, 4);
    setop(0, 3'b101, 32'd2, 32'd9);
    setop(1, 3'b101, 32'd2, 32'd9);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_grant", req_ready, (k % 2 == 0) ? 1 : 2);
      cyc();
      cyc();
      chk("rr_rspv", rsp_valid, (k % 2 == 0) ? 1 : 2);
      chk("rr_slt", rsp_result, 1);
      cyc();
    end
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    cyc();
    txn(0, 3'b110, 32'hFFFF_FFFF, 32'd1, 0);
    txn(0, 3'b000, 32'hFFFF_FFFF, 32'd1, 0);
    setop(0, 3'b000, 32'd1, 32'd2);
    req_valid = 2'b01;
    cyc();
    req_valid = 2'b00;
    chk("rst_exec_busy", busy, 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rst_exec_idle", busy, 0);
    chk("rst_exec_rspv", rsp_valid, 0);
    chk("rst_exec_result", rsp_result, 0);
    for (int k = 0; k < 4; k++) begin
      rsp_ready = 2'b11;
      cyc();
      chk("rst_no_late_rsp", rsp_valid, 0);
    end
    rsp_ready = 2'b00;
    pend = 2'b00;
    inflight = 1'b0;
    age = 0;
    owner = 0;
    nptr = 0;
    exp_r = '0;
    skip[0] = 0;
    skip[1] = 0;
    for (int c = 0; c < 620; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (c < 600 && !pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          pop[i] = 3'($urandom_range(0, 7));
          pa[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
          pb[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        end else if (pend[i] && $urandom_range(0, 15) == 0) pend[i] = 1'b0;
        setop(i, pop[i], pa[i], pb[i]);
      end
      req_valid = pend;
      rsp_ready = (c < 600) ? 2'($urandom_range(0, 3)) : 2'b11;
      #1;
      g = -1;
      if (!inflight)
        for (int k = 0; k < 2; k++)
          if (g < 0 && pend[(nptr + k) % 2]) g = (nptr + k) % 2;
      chk("r_ready", req_ready, (g < 0) ? 0 : (1 << g));
      chk("r_rspv", rsp_valid, (inflight && age >= 2) ? (1 << owner) : 0);
      chk("r_busy", busy, inflight);
      if (inflight && age >= 2) chk("r_result", {rsp_err, rsp_zero, rsp_result}, exp_r);
      if (|req_ready) begin
        for (int i = 0; i < 2; i++) begin
          skip[i] = req_ready[i] ? 0 : (pend[i] ? skip[i] + 1 : 0);
          chk("r_fair", skip[i] < 2, 1);
        end
      end
      if (g >= 0) begin
        inflight = 1'b1;
        age = 1;
        owner = g;
        nptr = (g + 1) % 2;
        exp_r = ref_alu(pop[g], pa[g], pb[g]);
        pend[g] = 1'b0;
      end else if (inflight) begin
        if (age >= 2 && rsp_ready[owner]) inflight = 1'b0;
        else age++;
      end
      cyc();
    end
    chk("r_drain", {inflight, busy}, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
